// File: rtl/noc_bridge_narrow_wide_pkg.sv
// Shared definitions for the narrow/wide NoC <-> AXIS bridge.
// The AXIS payload layout {flit_data, hdr} is defined once here and used by
// both the transmit and the receive side.
package noc_bridge_narrow_wide_pkg;

  localparam int unsigned HdrWidth           = 3;
  localparam int unsigned NarrowFlitDataSize = 16;
  localparam int unsigned WideFlitDataSize   = 64;

  // Channel header codes carried in the low bits of every AXIS beat.
  typedef enum logic [HdrWidth-1:0] {
    narrow_request  = 3'd1,
    narrow_response = 3'd2,
    wide_channel    = 3'd3
  } channel_hdr_e;

  // AXIS payload layout: flit data above the channel header.
  typedef struct packed {
    logic [WideFlitDataSize-1:0] flit_data;
    channel_hdr_e                hdr;
  } wide_axis_data_t;

  localparam int unsigned AxisDataWidth = HdrWidth + WideFlitDataSize;
  localparam int unsigned AxisStrbWidth = (AxisDataWidth + 7) / 8;
  localparam int unsigned AxisIdWidth   = 4;
  localparam int unsigned AxisDestWidth = 4;
  localparam int unsigned AxisUserWidth = 1;

  typedef logic [NarrowFlitDataSize-1:0] narrow_data_t;
  typedef logic [WideFlitDataSize-1:0]   wide_data_t;

  typedef struct packed {
    logic [AxisDataWidth-1:0] data;
    logic [AxisStrbWidth-1:0] strb;
    logic [AxisStrbWidth-1:0] keep;
    logic                     last;
    logic [AxisIdWidth-1:0]   id;
    logic [AxisDestWidth-1:0] dest;
    logic [AxisUserWidth-1:0] user;
  } nb_axis_t_chan_t;

  typedef struct packed {
    logic            tvalid;
    nb_axis_t_chan_t t;
  } nb_axis_req_t;

  typedef struct packed {
    logic tready;
  } nb_axis_rsp_t;

  typedef struct packed {
    logic         valid;
    logic         ready;
    narrow_data_t data;
  } nb_narrow_req_flit_t;

  typedef struct packed {
    logic         valid;
    logic         ready;
    narrow_data_t data;
  } nb_narrow_rsp_flit_t;

  typedef struct packed {
    logic       valid;
    logic       ready;
    wide_data_t data;
  } nb_wide_flit_t;

  // True for the three header codes that map to a NoC channel.
  function automatic logic hdr_is_legal(channel_hdr_e hdr);
    logic legal;
    case (hdr)
      narrow_request, narrow_response, wide_channel: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/floo_sync_fifo.sv
// Synchronous-reset FIFO with valid/ready on both sides and no fall-through:
// a pushed entry becomes visible on the output one cycle later.
module floo_sync_fifo #(
  parameter type         T     = logic,
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  T                mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push, pop;

  // Full is taken from registered state, so a same-cycle pop never frees a slot early.
  assign ready_o = (cnt_q != CntW'(Depth));
  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next-state for pointers and occupancy count.
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers; reset empties the FIFO and discards its contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write; entries need no reset since the count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/floo_axis_noc_demux_narrow_wide.sv
// Receive side of the NoC <-> AXIS bridge: decodes the channel header of
// each incoming beat and stores it in the matching per-channel FIFO.
// Beats with an unknown header are accepted, dropped and counted.
module floo_axis_noc_demux_narrow_wide
  import noc_bridge_narrow_wide_pkg::*;
#(
  parameter int unsigned NarrowDepth       = 4,
  parameter int unsigned WideDepth         = 4,
  parameter int unsigned ErrCntWidth       = 8,
  parameter type         narrow_req_flit_t = nb_narrow_req_flit_t,
  parameter type         narrow_rsp_flit_t = nb_narrow_rsp_flit_t,
  parameter type         wide_flit_t       = nb_wide_flit_t,
  parameter type         axis_req_t        = nb_axis_req_t,
  parameter type         axis_rsp_t        = nb_axis_rsp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  axis_req_t              axis_in_req_i,
  output axis_rsp_t              axis_in_rsp_o,
  output narrow_req_flit_t       narrow_req_o,
  input  narrow_req_flit_t       narrow_req_i,
  output narrow_rsp_flit_t       narrow_rsp_o,
  input  narrow_rsp_flit_t       narrow_rsp_i,
  output wide_flit_t             wide_o,
  input  wide_flit_t             wide_i,
  input  logic                   err_clr_i,
  output logic                   err_sticky_o,
  output logic [ErrCntWidth-1:0] drop_cnt_o
);

  wide_axis_data_t        in_data;
  channel_hdr_e           in_hdr;
  logic                   in_legal;
  logic                   tready;
  logic                   drop;

  logic                   req_in_valid, req_in_ready, req_out_valid;
  logic                   rsp_in_valid, rsp_in_ready, rsp_out_valid;
  logic                   wide_in_valid, wide_in_ready, wide_out_valid;
  narrow_data_t           req_out_data, rsp_out_data;
  wide_data_t             wide_out_data;

  logic [ErrCntWidth-1:0] drop_cnt_q, drop_cnt_d;
  logic                   err_sticky_q, err_sticky_d;

  // Sideband and the flit inputs' valid/data fields carry nothing for this block.
  logic                   unused_in;
  assign unused_in = ^{axis_in_req_i.t.strb, axis_in_req_i.t.keep, axis_in_req_i.t.last,
                       axis_in_req_i.t.id, axis_in_req_i.t.dest, axis_in_req_i.t.user,
                       narrow_req_i.valid, narrow_req_i.data,
                       narrow_rsp_i.valid, narrow_rsp_i.data,
                       wide_i.valid, wide_i.data};

  assign in_data  = axis_in_req_i.t.data;
  assign in_hdr   = in_data.hdr;
  assign in_legal = hdr_is_legal(in_hdr);

  // Ready depends on the header (tdata) and FIFO state only, never on tvalid.
  always_comb begin
    tready = 1'b1;
    case (in_hdr)
      narrow_request:  tready = req_in_ready;
      narrow_response: tready = rsp_in_ready;
      wide_channel:    tready = wide_in_ready;
      default:         tready = 1'b1;
    endcase
    if (rst_i) begin
      tready = 1'b0;
    end
  end

  assign req_in_valid  = axis_in_req_i.tvalid & (in_hdr == narrow_request) & ~rst_i;
  assign rsp_in_valid  = axis_in_req_i.tvalid & (in_hdr == narrow_response) & ~rst_i;
  assign wide_in_valid = axis_in_req_i.tvalid & (in_hdr == wide_channel) & ~rst_i;
  assign drop          = axis_in_req_i.tvalid & tready & ~in_legal;

  floo_sync_fifo #(
    .T     (narrow_data_t),
    .Depth (NarrowDepth)
  ) i_req_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (req_in_valid),
    .ready_o (req_in_ready),
    .data_i  (in_data.flit_data[NarrowFlitDataSize-1:0]),
    .valid_o (req_out_valid),
    .ready_i (narrow_req_i.ready),
    .data_o  (req_out_data)
  );

  floo_sync_fifo #(
    .T     (narrow_data_t),
    .Depth (NarrowDepth)
  ) i_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (rsp_in_valid),
    .ready_o (rsp_in_ready),
    .data_i  (in_data.flit_data[NarrowFlitDataSize-1:0]),
    .valid_o (rsp_out_valid),
    .ready_i (narrow_rsp_i.ready),
    .data_o  (rsp_out_data)
  );

  floo_sync_fifo #(
    .T     (wide_data_t),
    .Depth (WideDepth)
  ) i_wide_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (wide_in_valid),
    .ready_o (wide_in_ready),
    .data_i  (in_data.flit_data),
    .valid_o (wide_out_valid),
    .ready_i (wide_i.ready),
    .data_o  (wide_out_data)
  );

  // Drop bookkeeping: a clear wins over a same-cycle drop; the counter saturates.
  always_comb begin
    drop_cnt_d   = drop_cnt_q;
    err_sticky_d = err_sticky_q;
    if (err_clr_i) begin
      drop_cnt_d   = '0;
      err_sticky_d = 1'b0;
    end else if (drop) begin
      err_sticky_d = 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
  end

  // Drop counter and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_q   <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      drop_cnt_q   <= drop_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign drop_cnt_o   = drop_cnt_q;
  assign err_sticky_o = err_sticky_q;

  // Pack FIFO heads onto the outgoing flit structs; the ready fields are unused outputs.
  always_comb begin
    axis_in_rsp_o        = '0;
    axis_in_rsp_o.tready = tready;
    narrow_req_o         = '0;
    narrow_req_o.valid   = req_out_valid;
    narrow_req_o.data    = req_out_data;
    narrow_rsp_o         = '0;
    narrow_rsp_o.valid   = rsp_out_valid;
    narrow_rsp_o.data    = rsp_out_data;
    wide_o               = '0;
    wide_o.valid         = wide_out_valid;
    wide_o.data          = wide_out_data;
  end

endmodule
